// File: rtl/wishbone_arbiter_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
//   arb_state_e : arbiter FSM states
//   rr_next     : wrapping increment of a master index
package wishbone_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    // Next index after idx in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wishbone_rr_select.sv
// Combinational round-robin picker.
//   req    : one request bit per master
//   start  : index with highest priority this cycle; priority falls off
//            in increasing index order, wrapping
//   winner : first requesting index at or after start
//   valid  : any request present
module wishbone_rr_select #(
    parameter  int p_num_masters = 2,
    localparam int c_idx_nbits   = $clog2(p_num_masters)
) (
    input  logic [p_num_masters-1:0] req,
    input  logic [c_idx_nbits-1:0]   start,
    output logic [c_idx_nbits-1:0]   winner,
    output logic                     valid
);

    int unsigned              idx;
    logic [c_idx_nbits-1:0]   idx_w;

    // Walk the ring from the far end back to start so the lowest offset
    // from start is written last and therefore wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        idx_w  = '0;
        for (int k = p_num_masters - 1; k >= 0; k--) begin
            idx   = (32'(start) + 32'(k)) % 32'(p_num_masters);
            idx_w = c_idx_nbits'(idx);
            if (req[idx_w]) begin
                winner = idx_w;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port between masters.
// An owner keeps the bus for its whole cyc; on release the next requester
// takes over the following cycle. A watchdog aborts a beat the slave never
// acks and returns a one-cycle error to the owner.
//   clk, reset           : clock, asynchronous active-low reset
//   m_*_i / m_*_o        : per-master Wishbone ports (packed per master)
//   wbs_*_o / wbs_*_i    : shared slave port
//   grant_o              : index of current owner
//   busy_o               : high while a master owns the bus (BUSY or ABORT)
module wishbone_arbiter
    import wishbone_arbiter_pkg::*;
#(
    parameter  int p_num_masters    = 2,
    parameter  int p_timeout_cycles = 255,
    localparam int c_idx_nbits      = $clog2(p_num_masters)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [p_num_masters-1:0]            m_cyc_i,
    input  logic [p_num_masters-1:0]            m_stb_i,
    input  logic [p_num_masters-1:0]            m_we_i,
    input  logic [p_num_masters-1:0][3:0]       m_sel_i,
    input  logic [p_num_masters-1:0][31:0]      m_adr_i,
    input  logic [p_num_masters-1:0][31:0]      m_dat_i,
    output logic [p_num_masters-1:0]            m_ack_o,
    output logic [p_num_masters-1:0]            m_err_o,
    output logic [p_num_masters-1:0][31:0]      m_dat_o,
    output logic                                wbs_cyc_o,
    output logic                                wbs_stb_o,
    output logic                                wbs_we_o,
    output logic [3:0]                          wbs_sel_o,
    output logic [31:0]                         wbs_adr_o,
    output logic [31:0]                         wbs_dat_o,
    input  logic                                wbs_ack_i,
    input  logic [31:0]                         wbs_dat_i,
    output logic [c_idx_nbits-1:0]              grant_o,
    output logic                                busy_o
);

    localparam int c_wd_nbits = $clog2(p_timeout_cycles + 1);

    arb_state_e               state, state_nxt;
    logic [c_idx_nbits-1:0]   grant, grant_nxt;
    logic [c_idx_nbits-1:0]   last_grant, last_grant_nxt;
    logic [c_wd_nbits-1:0]    wd_cnt, wd_cnt_nxt;

    logic [c_idx_nbits-1:0]   rr_base;
    logic [c_idx_nbits-1:0]   rr_start;
    logic [c_idx_nbits-1:0]   pick_idx;
    logic                     pick_vld;
    logic                     own_cyc;
    logic                     own_stb;
    logic                     timeout;

    assign own_cyc = m_cyc_i[grant];
    assign own_stb = m_stb_i[grant];

    // From IDLE search after the previous owner; on release search after
    // the current owner, whose cyc is already low so it cannot win.
    assign rr_base  = (state == IDLE) ? last_grant : grant;
    assign rr_start = c_idx_nbits'(rr_next(32'(rr_base), p_num_masters));

    wishbone_rr_select #(
        .p_num_masters (p_num_masters)
    ) u_rr_select (
        .req    (m_cyc_i),
        .start  (rr_start),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    // Qualified on !ack so err and ack can never coincide.
    assign timeout = (state == BUSY) && own_cyc && own_stb && !wbs_ack_i &&
                     (wd_cnt == c_wd_nbits'(p_timeout_cycles));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= c_idx_nbits'(p_num_masters - 1);
            wd_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            wd_cnt     <= wd_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        wd_cnt_nxt     = '0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_nxt = pick_idx;
                    state_nxt = BUSY;
                end
            end
            BUSY, ABORT: begin
                if (!own_cyc) begin
                    // Release, with direct handoff if anyone else is waiting.
                    last_grant_nxt = grant;
                    if (pick_vld) begin
                        grant_nxt = pick_idx;
                        state_nxt = BUSY;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (state == BUSY) begin
                    if (timeout) begin
                        state_nxt = ABORT;
                    end else if (own_stb && !wbs_ack_i) begin
                        wd_cnt_nxt = wd_cnt + c_wd_nbits'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slave side: only the owner in BUSY reaches the bridge.
    always_comb begin
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_we_o  = 1'b0;
        wbs_sel_o = '0;
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        if (state == BUSY) begin
            wbs_cyc_o = own_cyc;
            wbs_stb_o = own_stb;
            wbs_we_o  = m_we_i[grant];
            wbs_sel_o = m_sel_i[grant];
            wbs_adr_o = m_adr_i[grant];
            wbs_dat_o = m_dat_i[grant];
        end
    end

    // Master side: non-owners see all zeros.
    for (genvar i = 0; i < p_num_masters; i++) begin : g_port
        logic own;
        assign own        = (state == BUSY) && (grant == c_idx_nbits'(i));
        assign m_ack_o[i] = own & wbs_ack_i & m_stb_i[i];
        assign m_err_o[i] = own & timeout;
        assign m_dat_o[i] = own ? wbs_dat_i : 32'h0;
    end

    assign grant_o = grant;
    assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_wishbone_arbiter.sv
module tb_wishbone_arbiter;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         m_cyc_i, m_stb_i, m_we_i;
    logic [1:0][3:0]    m_sel_i;
    logic [1:0][31:0]   m_adr_i, m_dat_i;
    logic [1:0]         m_ack_o, m_err_o;
    logic [1:0][31:0]   m_dat_o;
    logic               wbs_cyc_o, wbs_stb_o, wbs_we_o;
    logic [3:0]         wbs_sel_o;
    logic [31:0]        wbs_adr_o, wbs_dat_o;
    logic               wbs_ack_i;
    logic [31:0]        wbs_dat_i;
    logic [0:0]         grant_o;
    logic               busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] SDAT = 32'hA5A5_0001;

    wishbone_arbiter #(.p_num_masters(2), .p_timeout_cycles(4)) dut (
        .clk(clk), .reset(reset),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
        .wbs_sel_o(wbs_sel_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
        .wbs_ack_i(wbs_ack_i), .wbs_dat_i(wbs_dat_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus plus the outputs expected during that cycle.
    typedef struct {
        logic       rst;
        logic [1:0] cyc, stb;
        logic       sack;
        logic       drv;    // owner's signals routed to the slave (BUSY)
        logic       wcyc, wstb;
        logic       grant, busy;
        logic [1:0] ack, err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [1:0] cyc, logic [1:0] stb, logic sack,
                                logic drv, logic wcyc, logic wstb, logic grant,
                                logic busy, logic [1:0] ack, logic [1:0] err);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.stb = stb; v.sack = sack; v.drv = drv;
        v.wcyc = wcyc; v.wstb = wstb; v.grant = grant; v.busy = busy;
        v.ack = ack; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] cyc, input logic [1:0] stb, input logic sack);
        m_cyc_i = cyc; m_stb_i = stb; wbs_ack_i = sack;
    endtask

    // Whole-port check with the owner-routing rule applied to the expected grant.
    task automatic chk_vec(input string nm, input vec_t v);
        logic [63:0] bus_e, rd_e;
        logic        we_e;
        logic [3:0]  sel_e;
        we_e  = v.drv & m_we_i[v.grant];
        sel_e = v.drv ? m_sel_i[v.grant] : 4'h0;
        bus_e = v.drv ? {m_adr_i[v.grant], m_dat_i[v.grant]} : 64'h0;
        rd_e  = !v.drv ? 64'h0 : (v.grant ? {SDAT, 32'h0} : {32'h0, SDAT});
        chk({nm, ".ctl"},
            64'({wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, grant_o, busy_o, m_ack_o, m_err_o}),
            64'({v.wcyc, v.wstb, we_e, sel_e, v.grant, v.busy, v.ack, v.err}));
        chk({nm, ".bus"}, {wbs_adr_o, wbs_dat_o}, bus_e);
        chk({nm, ".rd"}, m_dat_o, rd_e);
    endtask

    initial begin
        reset     = 1'b0;
        m_cyc_i   = '0; m_stb_i = '0;
        m_we_i    = 2'b01;
        m_sel_i   = {4'h3, 4'hF};
        m_adr_i   = {32'h3000_0008, 32'h3000_0004};
        m_dat_i   = {32'h1234_5678, 32'hDEAD_BEEF};
        wbs_ack_i = 1'b0;
        wbs_dat_i = SDAT;

        // rst, cyc, stb, sack | drv, wcyc, wstb, grant, busy, ack, err
        // master 0 alone
        vecs.push_back(mk(0, 2'b01, 2'b01, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b01, 1, 1, 1, 1, 0, 1, 2'b01, 2'b00));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        // reset, then simultaneous requests and handoffs
        vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk(0, 2'b11, 2'b11, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk(0, 2'b11, 2'b11, 1, 1, 1, 1, 0, 1, 2'b01, 2'b00));
        vecs.push_back(mk(0, 2'b10, 2'b10, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00));
        vecs.push_back(mk(0, 2'b11, 2'b11, 1, 1, 1, 1, 1, 1, 2'b10, 2'b00));
        vecs.push_back(mk(0, 2'b11, 2'b11, 1, 1, 1, 1, 1, 1, 2'b10, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b01, 1, 1, 0, 0, 1, 1, 2'b00, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b01, 1, 1, 1, 1, 0, 1, 2'b01, 2'b00));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00));
        // master 1 holds 5 beats while master 0 waits
        vecs.push_back(mk(0, 2'b10, 2'b10, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 2'b11, 2'b11, 1, 1, 1, 1, 1, 1, 2'b10, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b01, 1, 1, 0, 0, 1, 1, 2'b00, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b01, 1, 1, 1, 1, 0, 1, 2'b01, 2'b00));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_vec("reset", mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            reset = !vecs[i].rst;
            drive(vecs[i].cyc, vecs[i].stb, vecs[i].sack);
            @(negedge clk);
            chk_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // watchdog: slave never acks, master 0 strobes
        @(posedge clk); #1; drive(2'b01, 2'b01, 0);      // IDLE, arbitration
        @(negedge clk);
        chk("to.idle_busy", 64'(busy_o), 64'd0);
        for (int i = 0; i <= 4; i++) begin               // first BUSY cycle + 4
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("to.stb%0d", i), 64'(wbs_stb_o), 64'd1);
            chk($sformatf("to.err%0d", i), 64'({m_err_o, m_ack_o}),
                (i == 4) ? 64'h4 : 64'h0);
        end
        for (int i = 0; i < 2; i++) begin                // ABORT with cyc held
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("to.abort%0d", i), 64'({wbs_cyc_o, wbs_stb_o, busy_o, m_err_o}),
                64'b00100);
        end
        @(posedge clk); #1; drive(2'b00, 2'b00, 0);
        @(negedge clk);
        chk("to.release", 64'({wbs_cyc_o, busy_o}), 64'b01);
        @(posedge clk); #1;
        @(negedge clk);
        chk("to.idle", 64'({wbs_cyc_o, busy_o}), 64'b00);

        // reset mid-BUSY with master 1 owning the bus
        @(posedge clk); #1; drive(2'b10, 2'b10, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst.own1", 64'({wbs_cyc_o, grant_o}), 64'b11);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("rst.async", 64'({wbs_cyc_o, wbs_stb_o, busy_o, grant_o, m_ack_o, m_err_o}),
            64'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(2'b11, 2'b11, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst.prio0", 64'({wbs_cyc_o, grant_o, m_ack_o}), 64'b1001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
